// File: rtl/reorder_buffer.sv
// Reorder buffer for the Tomasulo core.
// - Holds issued instructions in a circular buffer and retires them in program order, one per cycle.
// - Captures results from the ALU and LSB broadcast buses.
// - Answers operand-tag queries from the decoder, including a same-cycle bus bypass.
// - Flushes everything when a branch at the head turns out to be mispredicted.
module reorder_buffer #(
  parameter int ROB_SIZE       = 8,
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      issue_valid,
  input  logic [6:0]                issue_type,
  input  logic [4:0]                issue_rd,
  input  logic [31:0]               issue_pc,
  input  logic [31:0]               issue_target,
  input  logic                      issue_pred,
  output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  output logic                      rob_full,
  input  logic [ROB_SIZE_WIDTH-1:0] query_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] query_id2,
  output logic                      query_rdy1,
  output logic                      query_rdy2,
  output logic [31:0]               query_val1,
  output logic [31:0]               query_val2,
  input  logic                      rs_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]               rs_value,
  input  logic                      lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]               lsb_value,
  output logic                      commit_valid,
  output logic [4:0]                commit_rd,
  output logic [31:0]               commit_value,
  output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  output logic                      store_commit,
  output logic                      rob_clear,
  output logic [31:0]               redirect_pc
);

  localparam int         W         = ROB_SIZE_WIDTH;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [W:0] CNT_FULL  = (W+1)'(ROB_SIZE - 1);
  localparam logic [W:0] CNT_MAX   = (W+1)'(ROB_SIZE);

  // Per-entry control flags (reset) and payload (not reset)
  logic [ROB_SIZE-1:0] busy_q;
  logic [ROB_SIZE-1:0] ready_q;
  logic [ROB_SIZE-1:0] pred_q;
  logic [6:0]          type_q   [ROB_SIZE];
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [31:0]         pc_q     [ROB_SIZE];
  logic [31:0]         target_q [ROB_SIZE];
  logic [31:0]         value_q  [ROB_SIZE];

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [W:0]   count_q;
  logic [W:0]   count_d;

  logic do_commit;
  logic do_issue;
  logic head_is_branch;
  logic head_is_store;
  logic head_taken;
  logic mispredict;
  logic rs_wb;
  logic lsb_wb;

  // Operand lookup: a live bus result beats the stored entry.
  // A non-ready or free entry reads as not ready with value 0.
  function automatic logic [32:0] lookup(
    input logic [W-1:0] id,
    input logic         ent_ok,
    input logic [31:0]  ent_val,
    input logic         rs_v,
    input logic [W-1:0] rs_id,
    input logic [31:0]  rs_val,
    input logic         lsb_v,
    input logic [W-1:0] lsb_id,
    input logic [31:0]  lsb_val
  );
    logic [32:0] r;
    if (rs_v && rs_id == id)        r = {1'b1, rs_val};
    else if (lsb_v && lsb_id == id) r = {1'b1, lsb_val};
    else if (ent_ok)                r = {1'b1, ent_val};
    else                            r = '0;
    return r;
  endfunction

  assign issue_rob_id = tail_q;
  assign rob_full     = (count_q >= CNT_FULL);

  // Decode this cycle's commit, flush, issue and writeback decisions
  always_comb begin
    head_is_branch = (type_q[head_q] == OP_BRANCH);
    head_is_store  = (type_q[head_q] == OP_STORE);
    head_taken     = value_q[head_q][0];
    do_commit      = rdy && busy_q[head_q] && ready_q[head_q];
    mispredict     = do_commit && head_is_branch && (head_taken != pred_q[head_q]);
    do_issue       = rdy && issue_valid && !mispredict && (count_q != CNT_MAX);
    rs_wb          = rdy && rs_ready  && busy_q[rs_rob_id]  && !mispredict;
    lsb_wb         = rdy && lsb_ready && busy_q[lsb_rob_id] && !mispredict;
    count_d        = count_q + (W+1)'(do_issue) - (W+1)'(do_commit);
  end

  // Combinational operand queries for both decoder ports
  always_comb begin
    {query_rdy1, query_val1} = lookup(query_id1, busy_q[query_id1] & ready_q[query_id1],
                                      value_q[query_id1], rs_ready, rs_rob_id, rs_value,
                                      lsb_ready, lsb_rob_id, lsb_value);
    {query_rdy2, query_val2} = lookup(query_id2, busy_q[query_id2] & ready_q[query_id2],
                                      value_q[query_id2], rs_ready, rs_rob_id, rs_value,
                                      lsb_ready, lsb_rob_id, lsb_value);
  end

  // Control state and commit outputs.
  // A mispredict flush empties the buffer on the same edge that retires the branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      ready_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_valid  <= 1'b0;
      store_commit  <= 1'b0;
      rob_clear     <= 1'b0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_rob_id <= '0;
      redirect_pc   <= '0;
    end else if (rdy) begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      rob_clear    <= 1'b0;
      if (mispredict) begin
        busy_q  <= '0;
        ready_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (rs_wb)  ready_q[rs_rob_id]  <= 1'b1;
        if (lsb_wb) ready_q[lsb_rob_id] <= 1'b1;
        if (do_commit) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        if (do_issue) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= (issue_type == OP_STORE);
          tail_q          <= tail_q + 1'b1;
        end
        count_q <= count_d;
      end
      if (do_commit) begin
        commit_valid  <= 1'b1;
        commit_rd     <= (head_is_branch || head_is_store) ? 5'd0 : rd_q[head_q];
        commit_value  <= value_q[head_q];
        commit_rob_id <= head_q;
        store_commit  <= head_is_store;
      end
      if (mispredict) begin
        rob_clear   <= 1'b1;
        redirect_pc <= head_taken ? target_q[head_q] : pc_q[head_q] + 32'd4;
      end
    end else begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      rob_clear    <= 1'b0;
    end
  end

  // Entry payload: written at issue and on result capture
  always_ff @(posedge clk) begin
    if (do_issue) begin
      type_q[tail_q]   <= issue_type;
      rd_q[tail_q]     <= issue_rd;
      pc_q[tail_q]     <= issue_pc;
      target_q[tail_q] <= issue_target;
      pred_q[tail_q]   <= issue_pred;
    end
    if (rs_wb)  value_q[rs_rob_id]  <= rs_value;
    if (lsb_wb) value_q[lsb_rob_id] <= lsb_value;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer.
// - Directed sequences and a query vector table.
// - Randomized traffic checked against an in-order queue model.
module tb_reorder_buffer;

  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam int K_ALU = 0;
  localparam int K_ST  = 1;
  localparam int K_BR  = 2;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        issue_valid;
  logic [6:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic [31:0] issue_target;
  logic        issue_pred;
  logic [2:0]  issue_rob_id;
  logic        rob_full;
  logic [2:0]  query_id1;
  logic [2:0]  query_id2;
  logic        query_rdy1;
  logic        query_rdy2;
  logic [31:0] query_val1;
  logic [31:0] query_val2;
  logic        rs_ready;
  logic [2:0]  rs_rob_id;
  logic [31:0] rs_value;
  logic        lsb_ready;
  logic [2:0]  lsb_rob_id;
  logic [31:0] lsb_value;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [2:0]  commit_rob_id;
  logic        store_commit;
  logic        rob_clear;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.ROB_SIZE(8), .ROB_SIZE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_target(issue_target), .issue_pred(issue_pred),
    .issue_rob_id(issue_rob_id), .rob_full(rob_full),
    .query_id1(query_id1), .query_id2(query_id2),
    .query_rdy1(query_rdy1), .query_rdy2(query_rdy2),
    .query_val1(query_val1), .query_val2(query_val2),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_rob_id(commit_rob_id), .store_commit(store_commit),
    .rob_clear(rob_clear), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  qid;
    logic        rsv;
    logic [2:0]  rsid;
    logic [31:0] rsval;
    logic        lsv;
    logic [2:0]  lsid;
    logic [31:0] lsval;
    logic        exp_rdy;
    logic [31:0] exp_val;
  } qvec_t;

  typedef struct {
    int          tag;
    int          kind;
    logic [4:0]  rd;
    logic        pred;
    logic        rdy;
    logic [31:0] val;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    rs_ready    = 1'b0;
    lsb_ready   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_issue(input logic [6:0] ty, input logic [4:0] rd, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pr);
    issue_valid  = 1'b1;
    issue_type   = ty;
    issue_rd     = rd;
    issue_pc     = pc;
    issue_target = tgt;
    issue_pred   = pr;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic bcast_rs(input logic [2:0] id, input logic [31:0] v);
    rs_ready  = 1'b1;
    rs_rob_id = id;
    rs_value  = v;
    tick();
    rs_ready = 1'b0;
  endtask

  task automatic bcast_lsb(input logic [2:0] id, input logic [31:0] v);
    lsb_ready  = 1'b1;
    lsb_rob_id = id;
    lsb_value  = v;
    tick();
    lsb_ready = 1'b0;
  endtask

  // which: 0 = commit_valid, 1 = rob_clear
  task automatic wait_sig(input int which, input int maxc, input string name);
    int   n;
    logic s;
    n = 0;
    s = (which == 0) ? commit_valid : rob_clear;
    while (!s && n < maxc) begin
      tick();
      n++;
      s = (which == 0) ? commit_valid : rob_clear;
    end
    chk(name, s, 1'b1);
  endtask

  function automatic logic [31:0] mkval(input ent_t x);
    logic [31:0] v;
    v = $urandom;
    if (x.kind == K_BR) v[0] = x.pred;
    return v;
  endfunction

  task automatic query_table();
    qvec_t tbl[8];
    tbl[0] = '{3'd1, 1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  1'b1, 32'h11};
    tbl[1] = '{3'd0, 1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  1'b0, 32'h0};
    tbl[2] = '{3'd3, 1'b1, 3'd3, 32'h7,  1'b0, 3'd0, 32'h0,  1'b1, 32'h7};
    tbl[3] = '{3'd2, 1'b0, 3'd0, 32'h0,  1'b1, 3'd2, 32'h55, 1'b1, 32'h55};
    tbl[4] = '{3'd3, 1'b1, 3'd2, 32'h9,  1'b1, 3'd3, 32'h33, 1'b1, 32'h33};
    tbl[5] = '{3'd5, 1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  1'b0, 32'h0};
    tbl[6] = '{3'd1, 1'b1, 3'd1, 32'h99, 1'b0, 3'd0, 32'h0,  1'b1, 32'h99};
    tbl[7] = '{3'd0, 1'b1, 3'd2, 32'h44, 1'b1, 3'd3, 32'h66, 1'b0, 32'h0};
    do_reset();
    for (int i = 0; i < 4; i++) do_issue(OP_ALU, 5'(i + 1), 32'h0, 32'h0, 1'b0);
    bcast_rs(3'd1, 32'h11);
    for (int i = 0; i < 8; i++) begin
      query_id1  = tbl[i].qid;
      query_id2  = tbl[i].qid;
      rs_ready   = tbl[i].rsv;
      rs_rob_id  = tbl[i].rsid;
      rs_value   = tbl[i].rsval;
      lsb_ready  = tbl[i].lsv;
      lsb_rob_id = tbl[i].lsid;
      lsb_value  = tbl[i].lsval;
      #1;
      chk($sformatf("qtab%0d_rdy1", i), query_rdy1, tbl[i].exp_rdy);
      chk($sformatf("qtab%0d_val1", i), query_val1, tbl[i].exp_val);
      chk($sformatf("qtab%0d_rdy2", i), query_rdy2, tbl[i].exp_rdy);
      chk($sformatf("qtab%0d_val2", i), query_val2, tbl[i].exp_val);
      idle();
      tick();
    end
  endtask

  task automatic rand_test();
    ent_t        mq[$];
    ent_t        e;
    int          cand[$];
    int          qc[$];
    int          next_tag, a, b, k, r, kind;
    logic        drain, iss, qexp;
    logic [31:0] va, vb, qval;
    do_reset();
    next_tag = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (commit_valid) begin
        if (mq.size() == 0) chk("rnd_spurious_commit", 1, 0);
        else begin
          e = mq.pop_front();
          chk("rnd_commit_id", 32'(commit_rob_id), 32'(e.tag));
          chk("rnd_commit_rd", 32'(commit_rd), (e.kind == K_ALU) ? 32'(e.rd) : 32'd0);
          chk("rnd_store_commit", 32'(store_commit), (e.kind == K_ST) ? 32'd1 : 32'd0);
          if (e.kind != K_ST) chk("rnd_commit_val", commit_value, e.val);
        end
      end
      if (cyc >= 400 && mq.size() == 0) break;
      chk("rnd_full", rob_full, mq.size() >= 7);
      chk("rnd_tag", 32'(issue_rob_id), 32'(next_tag));
      chk("rnd_noclear", rob_clear, 1'b0);
      drain = (cyc >= 400);
      rdy   = drain ? 1'b1 : ($urandom_range(0, 9) != 0);
      cand.delete();
      qc.delete();
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].rdy) cand.push_back(i);
        if (mq[i].kind != K_ST) qc.push_back(i);
      end
      a = -1;
      b = -1;
      rs_ready  = 1'b0;
      lsb_ready = 1'b0;
      if (cand.size() > 0 && (drain || $urandom_range(0, 1) == 1)) begin
        a = cand[$urandom_range(0, cand.size() - 1)];
        va = mkval(mq[a]);
        rs_ready  = 1'b1;
        rs_rob_id = 3'(mq[a].tag);
        rs_value  = va;
      end
      if (cand.size() > 1 && $urandom_range(0, 1) == 1) begin
        for (int t = 0; t < 8 && (b < 0 || b == a); t++) b = cand[$urandom_range(0, cand.size() - 1)];
        if (b == a) b = -1;
        else begin
          vb = mkval(mq[b]);
          lsb_ready  = 1'b1;
          lsb_rob_id = 3'(mq[b].tag);
          lsb_value  = vb;
        end
      end
      qexp = 1'b0;
      qval = 32'h0;
      if (qc.size() > 0) begin
        k = qc[$urandom_range(0, qc.size() - 1)];
        query_id1 = 3'(mq[k].tag);
        if (k == a)             begin qexp = 1'b1; qval = va; end
        else if (k == b)        begin qexp = 1'b1; qval = vb; end
        else if (mq[k].rdy)     begin qexp = 1'b1; qval = mq[k].val; end
      end else begin
        query_id1 = 3'(next_tag);
      end
      query_id2 = 3'(next_tag);
      iss = !drain && mq.size() < 7 && $urandom_range(0, 9) < 7;
      r = $urandom_range(0, 9);
      kind = (r < 6) ? K_ALU : (r < 8) ? K_ST : K_BR;
      issue_valid  = iss;
      issue_type   = (kind == K_ALU) ? OP_ALU : (kind == K_ST) ? OP_ST : OP_BR;
      issue_rd     = 5'($urandom);
      issue_pc     = $urandom;
      issue_target = $urandom;
      issue_pred   = 1'($urandom);
      #1;
      chk("rnd_query_rdy1", query_rdy1, qexp);
      if (qexp) chk("rnd_query_val1", query_val1, qval);
      chk("rnd_query_rdy2", query_rdy2, 1'b0);
      if (rdy) begin
        if (a >= 0) begin e = mq[a]; e.rdy = 1'b1; e.val = va; mq[a] = e; end
        if (b >= 0) begin e = mq[b]; e.rdy = 1'b1; e.val = vb; mq[b] = e; end
        if (iss) begin
          e.tag  = next_tag;
          e.kind = kind;
          e.rd   = issue_rd;
          e.pred = issue_pred;
          e.rdy  = (kind == K_ST);
          e.val  = 32'h0;
          mq.push_back(e);
          next_tag = (next_tag + 1) % 8;
        end
      end
      tick();
    end
    idle();
    rdy = 1'b1;
    chk("rnd_drained", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    issue_type = '0; issue_rd = '0; issue_pc = '0; issue_target = '0; issue_pred = 1'b0;
    query_id1 = '0; query_id2 = '0;
    rs_rob_id = '0; rs_value = '0; lsb_rob_id = '0; lsb_value = '0;
    idle();

    // Reset state
    do_reset();
    chk("rst_commit_valid", commit_valid, 1'b0);
    chk("rst_store_commit", store_commit, 1'b0);
    chk("rst_rob_clear", rob_clear, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_commit_rd", commit_rd, 5'd0);
    chk("rst_commit_value", commit_value, 32'h0);
    chk("rst_commit_rob_id", commit_rob_id, 3'd0);
    chk("rst_issue_rob_id", issue_rob_id, 3'd0);
    chk("rst_rob_full", rob_full, 1'b0);
    chk("rst_query_rdy1", query_rdy1, 1'b0);

    // Basic ALU retire
    do_issue(OP_ALU, 5'd5, 32'h40, 32'h0, 1'b0);
    chk("basic_tag_next", issue_rob_id, 3'd1);
    bcast_rs(3'd0, 32'h2A);
    wait_sig(0, 5, "basic_commit_seen");
    chk("basic_rd", commit_rd, 5'd5);
    chk("basic_value", commit_value, 32'h2A);
    chk("basic_rob_id", commit_rob_id, 3'd0);
    chk("basic_store", store_commit, 1'b0);
    tick();
    chk("basic_pulse_end", commit_valid, 1'b0);

    // Fill to full, then retire one
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_issue(OP_ALU, 5'(i + 1), 32'h0, 32'h0, 1'b0);
      chk($sformatf("full_after_%0d", i + 1), rob_full, (i == 6));
    end
    chk("full_tail", issue_rob_id, 3'd7);
    bcast_rs(3'd0, 32'h100);
    wait_sig(0, 5, "full_commit_seen");
    chk("full_commit_id", commit_rob_id, 3'd0);
    chk("full_released", rob_full, 1'b0);

    // Out-of-order completion retires in order
    do_reset();
    do_issue(OP_ALU, 5'd1, 32'h0, 32'h0, 1'b0);
    do_issue(OP_ALU, 5'd2, 32'h0, 32'h0, 1'b0);
    bcast_rs(3'd1, 32'h11);
    for (int i = 0; i < 3; i++) begin
      chk("ooo_hold", commit_valid, 1'b0);
      tick();
    end
    bcast_lsb(3'd0, 32'h10);
    wait_sig(0, 5, "ooo_first_seen");
    chk("ooo_first_id", commit_rob_id, 3'd0);
    chk("ooo_first_val", commit_value, 32'h10);
    chk("ooo_first_rd", commit_rd, 5'd1);
    tick();
    chk("ooo_second_valid", commit_valid, 1'b1);
    chk("ooo_second_id", commit_rob_id, 3'd1);
    chk("ooo_second_val", commit_value, 32'h11);

    // Both buses in the same cycle
    do_issue(OP_ALU, 5'd3, 32'h0, 32'h0, 1'b0);
    do_issue(OP_ALU, 5'd4, 32'h0, 32'h0, 1'b0);
    rs_ready = 1'b1; rs_rob_id = 3'd2; rs_value = 32'hA0A0;
    lsb_ready = 1'b1; lsb_rob_id = 3'd3; lsb_value = 32'hB0B0;
    tick();
    idle();
    wait_sig(0, 5, "dual_first_seen");
    chk("dual_first_val", commit_value, 32'hA0A0);
    tick();
    chk("dual_second_valid", commit_valid, 1'b1);
    chk("dual_second_val", commit_value, 32'hB0B0);

    // Mispredict, actually taken; the issue in the flush cycle is dropped
    do_reset();
    do_issue(OP_BR, 5'd9, 32'h100, 32'h200, 1'b0);
    do_issue(OP_ALU, 5'd7, 32'h104, 32'h0, 1'b0);
    bcast_rs(3'd0, 32'h1);
    do_issue(OP_ALU, 5'd8, 32'h108, 32'h0, 1'b0);
    wait_sig(1, 5, "mp1_clear_seen");
    chk("mp1_redirect", redirect_pc, 32'h200);
    chk("mp1_commit_valid", commit_valid, 1'b1);
    chk("mp1_commit_rd", commit_rd, 5'd0);
    chk("mp1_tail_reset", issue_rob_id, 3'd0);
    chk("mp1_not_full", rob_full, 1'b0);
    query_id1 = 3'd1;
    #1;
    chk("mp1_stale_query", query_rdy1, 1'b0);
    tick();
    chk("mp1_pulse_end", rob_clear, 1'b0);
    bcast_rs(3'd1, 32'h5);
    for (int i = 0; i < 3; i++) begin
      chk("mp1_no_commit", commit_valid, 1'b0);
      tick();
    end

    // Mispredict, actually not taken
    do_reset();
    do_issue(OP_BR, 5'd0, 32'h100, 32'h200, 1'b1);
    bcast_rs(3'd0, 32'h0);
    wait_sig(1, 5, "mp2_clear_seen");
    chk("mp2_redirect", redirect_pc, 32'h104);

    // Correct prediction retires without a flush
    do_reset();
    do_issue(OP_BR, 5'd6, 32'h300, 32'h400, 1'b1);
    bcast_lsb(3'd0, 32'h1);
    wait_sig(0, 5, "bok_commit_seen");
    chk("bok_no_clear", rob_clear, 1'b0);
    chk("bok_rd", commit_rd, 5'd0);
    chk("bok_tail_kept", issue_rob_id, 3'd1);

    // Store is ready at issue
    do_reset();
    do_issue(OP_ST, 5'd9, 32'h500, 32'h0, 1'b0);
    wait_sig(0, 5, "st_commit_seen");
    chk("st_store_commit", store_commit, 1'b1);
    chk("st_rd", commit_rd, 5'd0);
    tick();
    chk("st_pulse_end", store_commit, 1'b0);

    // rdy low freezes everything
    do_reset();
    do_issue(OP_ALU, 5'd3, 32'h0, 32'h0, 1'b0);
    bcast_rs(3'd0, 32'h77);
    rdy = 1'b0;
    issue_valid = 1'b1; issue_type = OP_ALU; issue_rd = 5'd12;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_no_commit", commit_valid, 1'b0);
      chk("frz_tail", issue_rob_id, 3'd1);
    end
    issue_valid = 1'b0;
    rdy = 1'b1;
    wait_sig(0, 5, "frz_commit_seen");
    chk("frz_value", commit_value, 32'h77);
    chk("frz_rd", commit_rd, 5'd3);
    chk("frz_id", commit_rob_id, 3'd0);
    chk("frz_tail_after", issue_rob_id, 3'd1);

    query_table();
    rand_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
